unsigned_16by8_seq_div: RTL and testbench

//   Iterative radix-2 restoring unsigned divider, the inverse operation of the
//   8x8 unsigned multipliers: divides a 16-bit product-width dividend by an
//   8-bit divisor, one quotient bit per clock.

---
 rtl/unsigned_16by8_seq_div.sv | 110 +++++++++++
 tb/tb_unsigned_16by8_seq_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/unsigned_16by8_seq_div.sv
// Iterative radix-2 restoring unsigned divider, 16-bit dividend by 8-bit divisor.
// One quotient bit per clock, valid/ready on both sides, one operation in flight.
module unsigned_16by8_seq_div #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  q_ovf
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W-1:0]  r_rem;

    logic [DIVISOR_W:0]    w_rem_sh;
    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_rem_nx;
    logic [DIVIDEND_W-1:0] w_q_nx;

    // Quotient bits shift into the dividend register as dividend bits leave it.
    assign w_rem_sh = {r_rem, r_dvd[DIVIDEND_W-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_nx = w_rem_sh[DIVISOR_W-1:0] - (w_qbit ? r_dsr : '0);
    assign w_q_nx   = {r_dvd[DIVIDEND_W-2:0], w_qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        r_dvd    <= dividend;
                        r_dsr    <= divisor;
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                            q_ovf       <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_dvd <= w_q_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= w_q_nx;
                        remainder   <= w_rem_nx;
                        div_by_zero <= 1'b0;
                        q_ovf       <= |w_q_nx[DIVIDEND_W-1:DIVISOR_W];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Directed bench for unsigned_16by8_seq_div: latency, flags, hold,
// mid-run reset and a product-inverse sweep.
module tb_unsigned_16by8_seq_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        q_ovf;

    int nchk;
    int nerr;
    int lat;

    unsigned_16by8_seq_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .q_ovf       (q_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int n);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n == 1)
                chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid) break;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        nchk      = 0;
        nerr      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, q_ovf}, 32'd0);
        rst = 1'b0;

        run_op(16'd65025, 8'd255, lat);
        chk("lat_65025", 32'(lat), 32'd17);
        chk("q_65025", 32'(quotient), 32'd255);
        chk("r_65025", 32'(remainder), 32'd0);
        chk("f_65025", {30'd0, div_by_zero, q_ovf}, 32'd0);
        consume();

        run_op(16'hFFFF, 8'd1, lat);
        chk("q_ffff", 32'(quotient), 32'hFFFF);
        chk("r_ffff", 32'(remainder), 32'd0);
        chk("ovf_ffff", 32'(q_ovf), 32'd1);
        chk("dbz_ffff", 32'(div_by_zero), 32'd0);
        consume();

        run_op(16'h1234, 8'd0, lat);
        chk("lat_dbz", 32'(lat), 32'd1);
        chk("q_dbz", 32'(quotient), 32'hFFFF);
        chk("r_dbz", 32'(remainder), 32'h34);
        chk("dbz_flag", 32'(div_by_zero), 32'd1);
        chk("ovf_dbz", 32'(q_ovf), 32'd1);
        consume();

        run_op(16'd1000, 8'd7, lat);
        chk("lat_1000", 32'(lat), 32'd17);
        in_valid = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_q", 32'(quotient), 32'd142);
            chk("hold_r", 32'(remainder), 32'd6);
            chk("hold_ovf", 32'(q_ovf), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        chk("idle_q_held", 32'(quotient), 32'd142);
        repeat (3) @(negedge clk);
        chk("no_queued_op", 32'(out_valid), 32'd0);

        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("discarded_op", 32'(out_valid), 32'd0);

        run_op(16'd200, 8'd3, lat);
        chk("q_200", 32'(quotient), 32'd66);
        chk("r_200", 32'(remainder), 32'd2);
        consume();

        for (int k = 0; k < 20; k++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(1, 255));
            run_op(16'(x) * 16'(y), y, lat);
            chk("sweep_q", 32'(quotient), 32'(x));
            chk("sweep_r", 32'(remainder), 32'd0);
            chk("sweep_ovf", 32'(q_ovf), 32'd0);
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
